// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Control sequencer for a multi-cycle MIPS-subset datapath. Each instruction
//   moves through FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK). The
//   instruction word is held in an internal register (ir). Both memories use
//   req/ready handshakes. A wait counter turns a stalled handshake into a
//   sticky fault after MEM_TIMEOUT ready-low cycles.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   imem_rdata/ready      instruction word and instruction-memory handshake
//   dmem_ready            data-memory handshake
//   alu_zero              ALU zero flag, used by BEQ/BNE in EXECUTE
//   imem_req, dmem_req    memory request strobes
//   data_mem_wren         byte write mask for stores
//   reg_file_*            register file write strobe and input mux selects
//   alu_*                 ALU operand mux, operation and shift amount
//   pc_control, pc_wren   next-PC source and PC load strobe
//   retire                one pulse per completed instruction
//   fault, fault_cause    sticky fault flag and its cause

module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        dmem_req,
  output logic [3:0]  data_mem_wren,
  output logic        reg_file_wren,
  output logic        reg_file_dmux_select,
  output logic        reg_file_rmux_select,
  output logic        alu_mux_select,
  output logic [3:0]  alu_control,
  output logic [4:0]  alu_shamt,
  output logic [1:0]  pc_control,
  output logic        pc_wren,
  output logic        retire,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [31:0] ir;
  logic [7:0]  wait_cnt;
  logic [1:0]  cause;

  logic [5:0] opcode, funct;
  logic       is_rtype, is_j, is_jr, is_beq, is_bne, is_load, is_store;
  logic       is_pc_only, taken, legal;
  logic [3:0] alu_dec, store_mask;
  logic       imm_dec;

  // Register and immediate fields go straight to the datapath.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[25:11];

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign is_rtype = (opcode == 6'b000000);
  assign is_j     = (opcode == 6'b000010);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bne   = (opcode == 6'b000101);
  assign is_load  = (opcode == 6'b100011);
  assign is_store = (opcode == 6'b101000) || (opcode == 6'b101001) ||
                    (opcode == 6'b101011);
  // Instructions that finish in EXECUTE with only a PC update.
  assign is_pc_only = is_j || is_jr || is_beq || is_bne;
  assign taken      = (is_beq && alu_zero) || (is_bne && !alu_zero);
  assign alu_shamt  = ir[10:6];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011, 6'b001000, 6'b101010: legal = 1'b1;
          default: legal = (funct[5:3] == 3'b100);
        endcase
      end
      6'b000010, 6'b000100, 6'b000101,
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001111,
      6'b100011, 6'b101000, 6'b101001, 6'b101011: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // ALU operation, operand select and store byte mask from the held IR.
  always_comb begin
    alu_dec    = 4'b0100;
    imm_dec    = 1'b0;
    store_mask = 4'b0000;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: alu_dec = 4'b0101;
          6'b100001: alu_dec = 4'b0100;
          6'b100010: alu_dec = 4'b0111;
          6'b100011: alu_dec = 4'b0110;
          6'b100100: alu_dec = 4'b0000;
          6'b100101: alu_dec = 4'b0001;
          6'b100110: alu_dec = 4'b0010;
          6'b100111: alu_dec = 4'b0011;
          6'b101010: alu_dec = 4'b1000;
          6'b000000: alu_dec = 4'b1001;
          6'b000010: alu_dec = 4'b1010;
          6'b000011: alu_dec = 4'b1011;
          default:   alu_dec = 4'b0100;
        endcase
      end
      6'b000100, 6'b000101: alu_dec = 4'b0110;
      6'b001000: begin alu_dec = 4'b0101; imm_dec = 1'b1; end
      6'b001001: begin alu_dec = 4'b0100; imm_dec = 1'b1; end
      6'b001010: begin alu_dec = 4'b1000; imm_dec = 1'b1; end
      6'b001100: begin alu_dec = 4'b0000; imm_dec = 1'b1; end
      6'b001101: begin alu_dec = 4'b0001; imm_dec = 1'b1; end
      6'b001111: begin alu_dec = 4'b1100; imm_dec = 1'b1; end
      6'b100011: begin alu_dec = 4'b0100; imm_dec = 1'b1; end
      6'b101000: begin alu_dec = 4'b0100; imm_dec = 1'b1; store_mask = 4'b0001; end
      6'b101001: begin alu_dec = 4'b0100; imm_dec = 1'b1; store_mask = 4'b0011; end
      6'b101011: begin alu_dec = 4'b0100; imm_dec = 1'b1; store_mask = 4'b1111; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      ir       <= 32'd0;
      wait_cnt <= 8'd0;
      cause    <= 2'b00;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            state    <= S_DECODE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state    <= S_FAULT;
            cause    <= 2'b10;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          wait_cnt <= 8'd0;
          if (!legal) begin
            state <= S_FAULT;
            cause <= 2'b01;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          wait_cnt <= 8'd0;
          if (is_pc_only)                state <= S_FETCH;
          else if (is_load || is_store)  state <= S_MEMORY;
          else                           state <= S_WRITEBACK;
        end
        S_MEMORY: begin
          if (dmem_ready) begin
            state    <= is_store ? S_FETCH : S_WRITEBACK;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state    <= S_FAULT;
            cause    <= 2'b11;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WRITEBACK: begin
          wait_cnt <= 8'd0;
          state    <= S_FETCH;
        end
        default: begin
          wait_cnt <= 8'd0;
          state    <= S_FAULT;
        end
      endcase
    end
  end

  // Outputs decode from state/IR; rst forces the idle values without waiting
  // for a clock edge so no write strobe survives into reset.
  always_comb begin
    imem_req             = 1'b0;
    dmem_req             = 1'b0;
    data_mem_wren        = 4'b0000;
    reg_file_wren        = 1'b0;
    reg_file_dmux_select = 1'b0;
    reg_file_rmux_select = 1'b0;
    alu_mux_select       = 1'b0;
    alu_control          = 4'b0100;
    pc_control           = 2'b00;
    pc_wren              = 1'b0;
    retire               = 1'b0;
    fault                = 1'b0;
    fault_cause          = cause;
    if (!rst) begin
      case (state)
        S_FETCH: imem_req = 1'b1;
        S_EXECUTE: begin
          alu_control    = alu_dec;
          alu_mux_select = imm_dec;
          if (is_pc_only) begin
            pc_wren = 1'b1;
            retire  = 1'b1;
            if (is_j)       pc_control = 2'b01;
            else if (is_jr) pc_control = 2'b10;
            else if (taken) pc_control = 2'b11;
          end
        end
        S_MEMORY: begin
          alu_control    = alu_dec;
          alu_mux_select = imm_dec;
          dmem_req       = 1'b1;
          data_mem_wren  = store_mask;
          if (dmem_ready && is_store) begin
            pc_wren = 1'b1;
            retire  = 1'b1;
          end
        end
        S_WRITEBACK: begin
          alu_control          = alu_dec;
          alu_mux_select       = imm_dec;
          reg_file_wren        = 1'b1;
          reg_file_dmux_select = is_load;
          reg_file_rmux_select = is_rtype;
          pc_wren              = 1'b1;
          retire               = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Drives instruction sequences cycle by cycle. Each driven cycle pushes the
//   expected output word onto a queue; a monitor pops and compares it shortly
//   after the following falling edge.

module tb_multicycle_control_unit;

  localparam int MEM_TO = 4;
  localparam int K_JMP = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_ILL = 4;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic [3:0] wren;
    logic       rf;
    logic       dmux;
    logic       rmux;
    logic       amux;
    logic [3:0] alu;
    logic [4:0] shamt;
    logic [1:0] pc;
    logic       pcw;
    logic       ret;
    logic       flt;
    logic [1:0] cause;
  } o_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req, dmem_req, reg_file_wren, reg_file_dmux_select;
  logic        reg_file_rmux_select, alu_mux_select, pc_wren, retire, fault;
  logic [3:0]  data_mem_wren, alu_control;
  logic [4:0]  alu_shamt;
  logic [1:0]  pc_control, fault_cause;

  int n_checks = 0;
  int n_errors = 0;
  o_t    exp_q[$];
  string tag_q[$];
  logic [31:0] cur_ir = 32'd0;

  multicycle_control_unit #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(imem_req),
    .dmem_req(dmem_req), .data_mem_wren(data_mem_wren),
    .reg_file_wren(reg_file_wren), .reg_file_dmux_select(reg_file_dmux_select),
    .reg_file_rmux_select(reg_file_rmux_select), .alu_mux_select(alu_mux_select),
    .alu_control(alu_control), .alu_shamt(alu_shamt), .pc_control(pc_control),
    .pc_wren(pc_wren), .retire(retire), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic o_t observe();
    o_t o;
    o.imem_req = imem_req;        o.dmem_req = dmem_req;
    o.wren     = data_mem_wren;   o.rf       = reg_file_wren;
    o.dmux     = reg_file_dmux_select;
    o.rmux     = reg_file_rmux_select;
    o.amux     = alu_mux_select;  o.alu      = alu_control;
    o.shamt    = alu_shamt;       o.pc       = pc_control;
    o.pcw      = pc_wren;         o.ret      = retire;
    o.flt      = fault;           o.cause    = fault_cause;
    return o;
  endfunction

  function automatic o_t idle_o();
    o_t o;
    o       = '0;
    o.alu   = 4'b0100;
    o.shamt = cur_ir[10:6];
    return o;
  endfunction

  // Monitor: compares the expectation pushed for the cycle just entered.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        o_t    w;
        string t;
        w = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, 32'(observe()), 32'(w));
      end
    end
  end

  task automatic drive(input o_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  // Inputs outside a handshake are deliberately active/noisy: they must be ignored.
  task automatic idle_inputs();
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    imem_rdata = $urandom;
    alu_zero   = 1'($urandom_range(0, 1));
  endtask

  task automatic fault_run(input logic [1:0] c, input int n, input string tag);
    o_t e;
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      e = idle_o(); e.flt = 1'b1; e.cause = c;
      drive(e, {tag, "/fault"});
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    cur_ir = 32'd0;
    idle_inputs();
    drive(idle_o(), "reset");
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int kind, input logic [3:0] alu,
                           input logic amux, input logic rmux, input logic [3:0] mask,
                           input logic [1:0] pcsel, input logic z, input int iw,
                           input int dw, input int abort_at, input string tag);
    o_t e;
    for (int i = 0; i <= iw; i++) begin
      idle_inputs();
      imem_ready = (i == iw);
      e = idle_o(); e.imem_req = 1'b1;
      if (i == iw) imem_rdata = ir;
      drive(e, {tag, "/fetch"});
      if (i == iw) cur_ir = ir;
      else if (i == MEM_TO - 1) begin fault_run(2'b10, 5, tag); return; end
    end
    idle_inputs();
    drive(idle_o(), {tag, "/decode"});
    if (kind == K_ILL) begin fault_run(2'b01, 20, tag); return; end
    idle_inputs();
    alu_zero = z;
    e = idle_o(); e.alu = alu; e.amux = amux;
    if (kind == K_JMP) begin
      e.pc = pcsel; e.pcw = 1'b1; e.ret = 1'b1;
      drive(e, {tag, "/exec"});
      return;
    end
    drive(e, {tag, "/exec"});
    if (kind == K_LD || kind == K_ST) begin
      for (int i = 0; i <= dw; i++) begin
        idle_inputs();
        dmem_ready = (i == dw);
        e = idle_o(); e.dmem_req = 1'b1; e.wren = mask; e.alu = alu; e.amux = amux;
        if (i == dw && kind == K_ST) begin e.pcw = 1'b1; e.ret = 1'b1; end
        if (i == abort_at) begin
          exp_q.push_back(e);
          tag_q.push_back({tag, "/mem_before_rst"});
          #2 rst = 1'b1;
          cur_ir = 32'd0;
          #1;
          chk({tag, "/async_wren"}, 32'(data_mem_wren), 32'd0);
          chk({tag, "/async_idle"}, 32'(observe()), 32'(idle_o()));
          @(negedge clk);
          drive(idle_o(), {tag, "/rst_hold"});
          rst = 1'b0;
          return;
        end
        drive(e, {tag, "/mem"});
        if (i == dw && kind == K_ST) return;
        if (i != dw && i == MEM_TO - 1) begin fault_run(2'b11, 5, tag); return; end
      end
    end
    idle_inputs();
    e = idle_o(); e.rf = 1'b1; e.dmux = (kind == K_LD); e.rmux = rmux;
    e.amux = amux; e.alu = alu; e.pcw = 1'b1; e.ret = 1'b1;
    drive(e, {tag, "/wb"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    //         ir            kind   alu      am    rm    mask     pc     z     iw   dw  abort tag
    run_instr(32'h012A4020, K_ALU, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "add1");
    run_instr(32'h012A4020, K_ALU, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "add2");
    run_instr(32'h00094100, K_ALU, 4'b1001, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "sll");
    run_instr(32'h21280005, K_ALU, 4'b0101, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 3,   0, -1, "addi_iwait3");
    run_instr(32'h3C081234, K_ALU, 4'b1100, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "lui");
    run_instr(32'h8D280004, K_LD,  4'b0100, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 0,   3, -1, "lw_dwait3");
    run_instr(32'hA1280000, K_ST,  4'b0100, 1'b1, 1'b0, 4'b0001, 2'b00, 1'b0, 0,   0, -1, "sb");
    run_instr(32'hA5280000, K_ST,  4'b0100, 1'b1, 1'b0, 4'b0011, 2'b00, 1'b0, 0,   1, -1, "sh");
    run_instr(32'hAD280000, K_ST,  4'b0100, 1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 0,   0, -1, "sw");
    run_instr(32'h11090003, K_JMP, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b1, 0,   0, -1, "beq_taken");
    run_instr(32'h15090003, K_JMP, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b1, 0,   0, -1, "bne_not_taken");
    run_instr(32'h15090003, K_JMP, 4'b0110, 1'b0, 1'b0, 4'b0000, 2'b11, 1'b0, 0,   0, -1, "bne_taken");
    run_instr(32'h08000010, K_JMP, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'b01, 1'b0, 0,   0, -1, "j");
    run_instr(32'h01000008, K_JMP, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'b10, 1'b0, 0,   0, -1, "jr");
    run_instr(32'hAD280000, K_ST,  4'b0100, 1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 0,   5,  1, "sw_reset");
    run_instr(32'h012A4020, K_ALU, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "add_after_rst");
    run_instr(32'hFC000000, K_ILL, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "illegal_op");
    do_reset();
    run_instr(32'h00000001, K_ILL, 4'b0100, 1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "illegal_funct");
    do_reset();
    run_instr(32'h012A4020, K_ALU, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 100, 0, -1, "imem_timeout");
    do_reset();
    run_instr(32'hAD280000, K_ST,  4'b0100, 1'b1, 1'b0, 4'b1111, 2'b00, 1'b0, 0, 100, -1, "dmem_timeout");
    do_reset();
    run_instr(32'h012A4020, K_ALU, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'b00, 1'b0, 0,   0, -1, "add_final");
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
